// File: rtl/crc24_pkg.sv
// Shared BTLE CRC24 configuration: polynomial taps, framing defaults,
// sequencer state encoding and the single-bit LFSR step.
package crc24_pkg;

  localparam int          CRC_W           = 24;
  // x^24 + x^10 + x^9 + x^6 + x^4 + x^3 + x + 1 (x^24 implied by the shift)
  localparam logic [23:0] CRC_POLY_MASK   = 24'h00065B;
  // Preamble (8) + access address (32) bypass the CRC
  localparam int          HEADER_BITS_DEF = 40;
  localparam int          CLK_PER_BIT_DEF = 16;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,  // pass-through, CRC accumulating
    ST_CRC_OUT = 1'b1   // serialising the final LFSR state
  } crc_st_e;

  // One LFSR step: shift up, feed back s[23]^bit into bit 0 and the tap positions
  function automatic logic [23:0] crc24_step(input logic [23:0] s, input logic b);
    logic fb;
    fb = s[23] ^ b;
    return {s[22:0], 1'b0} ^ ({24{fb}} & CRC_POLY_MASK);
  endfunction

endpackage

// File: rtl/crc24_core.sv
// CRC24 LFSR with a load port (init / reload) and a per-bit update enable.
module crc24_core
  import crc24_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CRC_W-1:0] i_load_val,
  input  logic             i_update,
  input  logic             i_bit,
  output logic [CRC_W-1:0] o_state
);

  logic [CRC_W-1:0] r_lfsr;

  // LFSR register: a load overrides an update; otherwise the state holds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= 24'h000000;
    end else if (i_load) begin
      r_lfsr <= i_load_val;
    end else if (i_update) begin
      r_lfsr <= crc24_step(r_lfsr, i_bit);
    end else begin
      r_lfsr <= r_lfsr;
    end
  end

  assign o_state = r_lfsr;

endmodule

// File: rtl/crc24.sv
// BTLE CRC24 appender: passes the serial bit stream through with one cycle
// of latency, then emits the 24 CRC bits MSB-first, one per CLK_PER_BIT cycles.
module crc24
  import crc24_pkg::*;
#(
  parameter int CRC_STATE_BIT_WIDTH = CRC_W,
  parameter int HEADER_BITS         = HEADER_BITS_DEF,
  parameter int CLK_PER_BIT         = CLK_PER_BIT_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CRC_STATE_BIT_WIDTH-1:0] crc_state_init_bit,
  input  logic                           crc_state_init_bit_load,
  input  logic                           info_bit,
  input  logic                           info_bit_valid,
  input  logic                           info_bit_valid_last,
  output logic                           info_bit_after_crc24,
  output logic                           info_bit_after_crc24_valid,
  output logic                           info_bit_after_crc24_valid_last
);

  localparam int                BCNT_W       = 16;
  localparam int                CYC_W        = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT + 1) : 1;
  localparam logic [BCNT_W-1:0] HDR_CNT      = BCNT_W'(HEADER_BITS);
  localparam logic [CYC_W-1:0]  CYC_LAST     = CYC_W'(CLK_PER_BIT - 1);
  localparam logic [CYC_W-1:0]  CYC_ONE      = CYC_W'(1);
  localparam logic [4:0]        CRC_LAST_IDX = 5'(CRC_STATE_BIT_WIDTH - 1);

  crc_st_e                          r_state;
  crc_st_e                          w_state_next;
  logic [CRC_STATE_BIT_WIDTH-1:0]   r_init;
  logic [BCNT_W-1:0]                r_bit_cnt;
  logic [CYC_W-1:0]                 r_cyc_cnt;
  logic [4:0]                       r_crc_cnt;
  logic                             r_out_bit;
  logic                             r_out_valid;
  logic                             r_out_last;

  logic                             w_accept;
  logic                             w_end_pkt;
  logic                             w_emit;
  logic                             w_crc_done;
  logic                             w_core_load;
  logic                             w_core_update;
  logic [CRC_STATE_BIT_WIDTH-1:0]   w_core_load_val;
  logic [CRC_STATE_BIT_WIDTH-1:0]   w_crc_state;

  // Next-state and per-cycle strobes; an init load pre-empts every other action
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_end_pkt    = 1'b0;
    w_emit       = 1'b0;
    w_crc_done   = 1'b0;
    if (crc_state_init_bit_load) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_accept = info_bit_valid;
          if (info_bit_valid_last) begin
            w_end_pkt    = 1'b1;
            w_state_next = ST_CRC_OUT;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
        ST_CRC_OUT: begin
          w_emit = (r_cyc_cnt >= CYC_LAST);
          if (w_emit && (r_crc_cnt == CRC_LAST_IDX)) begin
            w_crc_done   = 1'b1;
            w_state_next = ST_IDLE;
          end else begin
            w_state_next = ST_CRC_OUT;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Header bits ride through untouched; the LFSR reloads after the final CRC bit
  assign w_core_update   = w_accept && (r_bit_cnt >= HDR_CNT);
  assign w_core_load     = crc_state_init_bit_load | w_crc_done;
  assign w_core_load_val = crc_state_init_bit_load ? crc_state_init_bit : r_init;

  crc24_core u_core (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_core_load),
    .i_load_val (w_core_load_val),
    .i_update   (w_core_update),
    .i_bit      (info_bit),
    .o_state    (w_crc_state)
  );

  // Sequencer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Stored init value, reused to reload the LFSR between packets
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_init <= '0;
    end else if (crc_state_init_bit_load) begin
      r_init <= crc_state_init_bit;
    end else begin
      r_init <= r_init;
    end
  end

  // Count accepted input bits (saturating) to tell header from payload
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt <= {BCNT_W{1'b0}};
    end else if (crc_state_init_bit_load || w_crc_done) begin
      r_bit_cnt <= {BCNT_W{1'b0}};
    end else if (w_accept && (r_bit_cnt != {BCNT_W{1'b1}})) begin
      r_bit_cnt <= r_bit_cnt + {{(BCNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_bit_cnt <= r_bit_cnt;
    end
  end

  // CRC bit pacing: the cycle count starts at 1 when valid_last trails the
  // last data bit, since that bit already left one cycle earlier
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cyc_cnt <= {CYC_W{1'b0}};
      r_crc_cnt <= 5'd0;
    end else if (crc_state_init_bit_load) begin
      r_cyc_cnt <= {CYC_W{1'b0}};
      r_crc_cnt <= 5'd0;
    end else if (w_end_pkt) begin
      r_cyc_cnt <= info_bit_valid ? {CYC_W{1'b0}} : CYC_ONE;
      r_crc_cnt <= 5'd0;
    end else if (w_emit) begin
      r_cyc_cnt <= {CYC_W{1'b0}};
      r_crc_cnt <= w_crc_done ? 5'd0 : (r_crc_cnt + 5'd1);
    end else if (r_state == ST_CRC_OUT) begin
      r_cyc_cnt <= r_cyc_cnt + CYC_ONE;
      r_crc_cnt <= r_crc_cnt;
    end else begin
      r_cyc_cnt <= r_cyc_cnt;
      r_crc_cnt <= r_crc_cnt;
    end
  end

  // Output register: data pass-through or CRC bit; the bit holds when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_bit   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (crc_state_init_bit_load) begin
      r_out_bit   <= r_out_bit;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_accept) begin
      r_out_bit   <= info_bit;
      r_out_valid <= 1'b1;
      r_out_last  <= 1'b0;
    end else if (w_emit) begin
      r_out_bit   <= w_crc_state[CRC_LAST_IDX - r_crc_cnt];
      r_out_valid <= 1'b1;
      r_out_last  <= w_crc_done;
    end else begin
      r_out_bit   <= r_out_bit;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign info_bit_after_crc24            = r_out_bit;
  assign info_bit_after_crc24_valid      = r_out_valid;
  assign info_bit_after_crc24_valid_last = r_out_last;

endmodule

// File: tb/tb_crc24.sv
// Bench for crc24: expected output stream is scheduled per cycle from a
// polynomial-division model; one negedge process compares every cycle.
module tb_crc24;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] crc_state_init_bit = 24'h0;
  logic        crc_state_init_bit_load = 1'b0;
  logic        info_bit = 1'b0;
  logic        info_bit_valid = 1'b0;
  logic        info_bit_valid_last = 1'b0;
  logic        o_bit, o_valid, o_last;

  crc24 dut (
    .clk                             (clk),
    .rst                             (rst),
    .crc_state_init_bit              (crc_state_init_bit),
    .crc_state_init_bit_load         (crc_state_init_bit_load),
    .info_bit                        (info_bit),
    .info_bit_valid                  (info_bit_valid),
    .info_bit_valid_last             (info_bit_valid_last),
    .info_bit_after_crc24            (o_bit),
    .info_bit_after_crc24_valid      (o_valid),
    .info_bit_after_crc24_valid_last (o_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // expected stream, keyed by the cycle number in which it must be visible
  bit exp_v [int];
  bit exp_b [int];
  bit exp_l [int];

  int          n_cmp = 0;
  int          n_bad = 0;
  logic        m_hold = 1'b0;
  logic [23:0] cap = 24'h0;
  logic [23:0] cap_done = 24'h0;
  logic [23:0] m_init = 24'h0;
  int          m_last = 0;

  // literal-check mailbox, serviced by the compare process
  int          chk_seq = 0;
  int          chk_seen = 0;
  string       chk_name = "";
  logic [23:0] chk_got = 24'h0;
  logic [23:0] chk_exp = 24'h0;

  // CRC as remainder of polynomial division: r = r*x + b*x^24 mod P
  function automatic logic [23:0] poly_step(input logic [23:0] c, input logic b);
    logic [24:0] r;
    r = {c, 1'b0} ^ {b, 24'h000000};
    if (r[24]) r = r ^ 25'h100065B;
    return r[23:0];
  endfunction

  function automatic logic [23:0] crc_bits(input logic [23:0] init, input logic [63:0] d, input int nd);
    logic [23:0] c;
    c = init;
    for (int i = 0; i < nd; i++) c = poly_step(c, d[i]);
    return c;
  endfunction

  // compare every cycle against the scheduled stream; collect received CRC
  always @(negedge clk) begin : cmp
    logic ev, el;
    ev = 1'b0;
    el = 1'b0;
    if (rst) begin
      m_hold = 1'b0;
    end else if (exp_v.exists(cyc)) begin
      ev     = 1'b1;
      el     = exp_l[cyc];
      m_hold = exp_b[cyc];
    end
    n_cmp++;
    if (o_valid !== ev || o_last !== el || o_bit !== m_hold) begin
      n_bad++;
      $display("FAIL out_stream cyc=%0d actual v/l/b=%b/%b/%b required %b/%b/%b",
               cyc, o_valid, o_last, o_bit, ev, el, m_hold);
    end
    if (!rst && o_valid === 1'b1) begin
      cap = {cap[22:0], o_bit};
      if (o_last === 1'b1) cap_done = cap;
    end
    if (chk_seq != chk_seen) begin
      chk_seen = chk_seq;
      n_cmp++;
      if (chk_got !== chk_exp) begin
        n_bad++;
        $display("FAIL %s actual=%06h required=%06h", chk_name, chk_got, chk_exp);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check24(input string name, input logic [23:0] got, input logic [23:0] exp);
    chk_name = name;
    chk_got  = got;
    chk_exp  = exp;
    chk_seq++;
    idle(1);
  endtask

  task automatic clear_from(input int c);
    for (int k = c; k < c + 1000; k++) begin
      if (exp_v.exists(k)) begin
        exp_v.delete(k);
        exp_b.delete(k);
        exp_l.delete(k);
      end
    end
  endtask

  task automatic do_load(input logic [23:0] v);
    crc_state_init_bit      = v;
    crc_state_init_bit_load = 1'b1;
    m_init                  = v;
    idle(1);
    crc_state_init_bit_load = 1'b0;
  endtask

  // drive 40 header bits + nd data bits; schedule echo and the 24 CRC bits
  task automatic send_pkt(input logic [39:0] hdr, input logic [63:0] data, input int nd, input bit late);
    logic [23:0] c;
    int total;
    c     = crc_bits(m_init, data, nd);
    total = 40 + nd;
    for (int i = 0; i < total; i++) begin
      info_bit            = (i < 40) ? hdr[i] : data[i-40];
      info_bit_valid      = 1'b1;
      info_bit_valid_last = (!late && i == total - 1);
      exp_v[cyc+1] = 1'b1;
      exp_b[cyc+1] = info_bit;
      exp_l[cyc+1] = 1'b0;
      m_last = cyc + 1;
      idle(1);
    end
    info_bit_valid      = 1'b0;
    info_bit_valid_last = 1'b0;
    if (late) begin
      info_bit_valid_last = 1'b1;
      idle(1);
      info_bit_valid_last = 1'b0;
    end
    for (int k = 0; k < 24; k++) begin
      exp_v[m_last + 16*(k+1)] = 1'b1;
      exp_b[m_last + 16*(k+1)] = c[23-k];
      exp_l[m_last + 16*(k+1)] = (k == 23);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) idle(1);
  endtask

  localparam logic [39:0] HDR_A = 40'h8E89BED6AA;
  localparam logic [39:0] HDR_B = 40'h7176412955;

  logic [23:0] crc_first;

  initial begin
    idle(3);
    rst = 1'b0;
    idle(2);

    // model pins, hand-computed
    check24("pin_single_one", crc_bits(24'h000000, 64'h1, 1), 24'h00065B);
    check24("pin_one_zero",   crc_bits(24'h000000, 64'h1, 2), 24'h000CB6);
    check24("pin_msb_fb",     crc_bits(24'h800000, 64'h0, 1), 24'h00065B);

    // single data bit 1 from zero init
    do_load(24'h000000);
    send_pkt(HDR_A, 64'h1, 1, 1'b0);
    idle(400);
    check24("crc_single_one", cap_done, 24'h00065B);

    // 16 zero data bits from zero init (uses reload of stored init)
    send_pkt(HDR_A, 64'h0, 16, 1'b0);
    idle(400);
    check24("crc_zeros", cap_done, 24'h000000);

    // no data: CRC equals the advertising init value
    do_load(24'h555555);
    send_pkt(HDR_A, 64'h0, 0, 1'b0);
    idle(400);
    check24("crc_empty_adv", cap_done, 24'h555555);

    // back-to-back with one load; input noise during CRC_OUT must be ignored
    send_pkt(HDR_A, 64'hA5C3, 16, 1'b0);
    for (int i = 0; i < 60; i++) begin
      info_bit       = i[0];
      info_bit_valid = (i % 3 != 0);
      idle(1);
    end
    info_bit_valid = 1'b0;
    idle(340);
    crc_first = cap_done;
    check24("crc_pkt1_model", crc_first, crc_bits(24'h555555, 64'hA5C3, 16));
    send_pkt(HDR_A, 64'hA5C3, 16, 1'b0);
    idle(400);
    check24("crc_pkt2_same", cap_done, crc_first);

    // header toggled, data fixed
    send_pkt(HDR_B, 64'hA5C3, 16, 1'b0);
    idle(400);
    check24("crc_hdr_toggled", cap_done, crc_first);

    // valid_last one cycle after the final data bit
    send_pkt(HDR_A, 64'h3C, 8, 1'b1);
    idle(400);
    check24("crc_late_last", cap_done, crc_bits(24'h555555, 64'h3C, 8));

    // init load aborts CRC_OUT
    send_pkt(HDR_A, 64'hF0, 8, 1'b0);
    wait_until(m_last + 16*5 + 3);
    clear_from(cyc + 1);
    do_load(24'h000000);
    idle(420);
    send_pkt(HDR_B, 64'h1, 1, 1'b0);
    idle(400);
    check24("crc_after_abort", cap_done, 24'h00065B);

    // reset during CRC bit 10, then reload and run a fresh packet
    do_load(24'h555555);
    send_pkt(HDR_A, 64'h1234, 16, 1'b0);
    wait_until(m_last + 16*10);
    rst = 1'b1;
    clear_from(cyc);
    idle(3);
    rst = 1'b0;
    idle(420);
    do_load(24'h555555);
    send_pkt(HDR_A, 64'h1234, 16, 1'b0);
    idle(400);
    check24("crc_after_reset", cap_done, crc_bits(24'h555555, 64'h1234, 16));

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
